traffic_light_hex_seq: RTL and testbench

- Sequences the traffic-light phases (GREEN, YELLOW, RED) and drives a per-phase seconds countdown onto the 8-bit HEX PIO.
- Acts as an Avalon-MM write-only master into the HEX PIO s1 slave: address 0, single-cycle writes, no waitrequest.
- Also exports a one-hot lamp vector for the light outputs.
- Sits between the system clock domain and the HEX PIO, replacing software-driven display updates.

---
 rtl/traffic_light_hex_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_traffic_light_hex_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_hex_seq.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_hex_seq
// Description : Steps through the traffic-light phases GREEN -> YELLOW -> RED
//               and counts down the seconds left in the current phase. The
//               count is shown on an 8-bit active-low seven-segment HEX PIO.
//               The block writes the PIO as an Avalon-MM write-only master
//               (slave s1, address 0, single-cycle writes, no waitrequest).
//               It also drives a one-hot lamp vector {red,yellow,green}.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TICK_DIV  clk cycles per one-second tick (2 .. 2**26)
//   GREEN_S   GREEN phase length in seconds  (1 .. 9)
//   YELLOW_S  YELLOW phase length in seconds (1 .. 9)
//   RED_S     RED phase length in seconds    (1 .. 9)
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   level: 1 runs the sequence, 0 returns to IDLE
//   force_red     in   one-cycle pulse: jump to RED and reload the full count
//   lamp          out  one-hot {red,yellow,green}; 000 in IDLE
//   m_address     out  PIO register address (always 0)
//   m_chipselect  out  one-cycle write strobe to the PIO
//   m_write_n     out  active-low write (always ~m_chipselect)
//   m_writedata   out  {24'b0, seg[7:0]}
// ============================================================================
module traffic_light_hex_seq #(
  parameter int TICK_DIV = 50000000,
  parameter int GREEN_S  = 9,
  parameter int YELLOW_S = 3,
  parameter int RED_S    = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        force_red,
  output logic [2:0]  lamp,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // 26 bits hold the largest legal terminal count, 2**26 - 1.
  localparam int                 c_PRE_W    = 26;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX  = c_PRE_W'(TICK_DIV - 1);

  localparam logic [3:0]         c_GREEN_LD  = 4'(GREEN_S);
  localparam logic [3:0]         c_YELLOW_LD = 4'(YELLOW_S);
  localparam logic [3:0]         c_RED_LD    = 4'(RED_S);

  localparam logic [1:0]         c_ST_IDLE   = 2'd0;
  localparam logic [1:0]         c_ST_GREEN  = 2'd1;
  localparam logic [1:0]         c_ST_YELLOW = 2'd2;
  localparam logic [1:0]         c_ST_RED    = 2'd3;

  localparam logic [2:0]         c_LAMP_OFF    = 3'b000;
  localparam logic [2:0]         c_LAMP_GREEN  = 3'b001;
  localparam logic [2:0]         c_LAMP_YELLOW = 3'b010;
  localparam logic [2:0]         c_LAMP_RED    = 3'b100;

  localparam logic [7:0]         c_SEG_BLANK = 8'hFF;
  // Clearing bit 7 lights the decimal point, which marks the YELLOW phase.
  localparam logic [7:0]         c_DP_MASK   = 8'h7F;

  // --------------------------------------------------------------------------
  // Configuration guards (evaluated at elaboration)
  // --------------------------------------------------------------------------
  if ((TICK_DIV < 2) || (TICK_DIV > 67108864)) begin : g_chk_tick_div
    $error("traffic_light_hex_seq: TICK_DIV=%0d outside 2..2**26", TICK_DIV);
  end
  if ((GREEN_S < 1) || (GREEN_S > 9)) begin : g_chk_green
    $error("traffic_light_hex_seq: GREEN_S=%0d outside 1..9", GREEN_S);
  end
  if ((YELLOW_S < 1) || (YELLOW_S > 9)) begin : g_chk_yellow
    $error("traffic_light_hex_seq: YELLOW_S=%0d outside 1..9", YELLOW_S);
  end
  if ((RED_S < 1) || (RED_S > 9)) begin : g_chk_red
    $error("traffic_light_hex_seq: RED_S=%0d outside 1..9", RED_S);
  end

  // --------------------------------------------------------------------------
  // Active-low seven-segment decode (bit 7 = decimal point, off)
  // --------------------------------------------------------------------------
  function automatic logic [7:0] f_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = c_SEG_BLANK;
    endcase
    return seg;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [3:0]         r_remaining;
  logic [c_PRE_W-1:0] r_prescaler;
  logic [2:0]         r_lamp;
  logic               r_chipselect;
  logic [7:0]         r_seg;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic               w_tick;
  logic [1:0]         w_state_nxt;
  logic [3:0]         w_remaining_nxt;
  logic [c_PRE_W-1:0] w_prescaler_nxt;
  logic               w_write;
  logic [2:0]         w_lamp_nxt;
  logic [7:0]         w_seg_nxt;

  // The prescaler only runs outside IDLE, so a tick never fires there.
  assign w_tick = (r_state != c_ST_IDLE) && (r_prescaler == c_PRE_MAX);

  // Priority: enable low, then force_red, then the IDLE start-up, then tick.
  // A write goes out whenever the state or the remaining count changes.
  // Every state entry clears the prescaler, so each displayed second
  // lasts a full TICK_DIV cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_prescaler_nxt = r_prescaler;
    w_write         = 1'b0;

    if (!enable) begin
      w_state_nxt     = c_ST_IDLE;
      w_remaining_nxt = 4'd0;
      w_prescaler_nxt = '0;
      // Write the blank pattern once, on entry to IDLE only.
      w_write         = (r_state != c_ST_IDLE);
    end else if (force_red) begin
      // Takes priority over a tick in the same cycle, so there is no
      // decrement. Re-entering RED from RED also reloads and restarts.
      w_state_nxt     = c_ST_RED;
      w_remaining_nxt = c_RED_LD;
      w_prescaler_nxt = '0;
      w_write         = 1'b1;
    end else if (r_state == c_ST_IDLE) begin
      w_state_nxt     = c_ST_GREEN;
      w_remaining_nxt = c_GREEN_LD;
      w_prescaler_nxt = '0;
      w_write         = 1'b1;
    end else if (w_tick) begin
      w_prescaler_nxt = '0;
      w_write         = 1'b1;
      if (r_remaining == 4'd1) begin
        case (r_state)
          c_ST_GREEN: begin
            w_state_nxt     = c_ST_YELLOW;
            w_remaining_nxt = c_YELLOW_LD;
          end
          c_ST_YELLOW: begin
            w_state_nxt     = c_ST_RED;
            w_remaining_nxt = c_RED_LD;
          end
          default: begin
            w_state_nxt     = c_ST_GREEN;
            w_remaining_nxt = c_GREEN_LD;
          end
        endcase
      end else begin
        w_remaining_nxt = r_remaining - 4'd1;
      end
    end else begin
      w_prescaler_nxt = r_prescaler + 1'b1;
    end
  end

  // Lamp and display pattern are derived from the next state, so they
  // change on the same edge as the state they describe.
  always_comb begin
    w_lamp_nxt = c_LAMP_OFF;
    w_seg_nxt  = c_SEG_BLANK;
    case (w_state_nxt)
      c_ST_GREEN: begin
        w_lamp_nxt = c_LAMP_GREEN;
        w_seg_nxt  = f_seg(w_remaining_nxt);
      end
      c_ST_YELLOW: begin
        w_lamp_nxt = c_LAMP_YELLOW;
        w_seg_nxt  = f_seg(w_remaining_nxt) & c_DP_MASK;
      end
      c_ST_RED: begin
        w_lamp_nxt = c_LAMP_RED;
        w_seg_nxt  = f_seg(w_remaining_nxt);
      end
      default: begin
        w_lamp_nxt = c_LAMP_OFF;
        w_seg_nxt  = c_SEG_BLANK;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_ST_IDLE;
      r_remaining  <= 4'd0;
      r_prescaler  <= '0;
      r_lamp       <= c_LAMP_OFF;
      r_chipselect <= 1'b0;
      r_seg        <= c_SEG_BLANK;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_prescaler  <= w_prescaler_nxt;
      r_lamp       <= w_lamp_nxt;
      // The strobe is recomputed every cycle, so it never lasts more than
      // one cycle unless a new change occurs in the next cycle.
      r_chipselect <= w_write;
      if (w_write) begin
        r_seg <= w_seg_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign lamp         = r_lamp;
  assign m_address    = 2'b00;
  assign m_chipselect = r_chipselect;
  assign m_write_n    = ~r_chipselect;
  assign m_writedata  = {24'h000000, r_seg};

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_hex_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_hex_seq
// Description : Directed self-checking bench for traffic_light_hex_seq. It
//               uses TICK_DIV=4 and the default phase lengths.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_traffic_light_hex_seq;

  localparam int TICK_DIV = 4;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        force_red;
  logic [2:0]  lamp;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  int errors = 0;
  int checks = 0;

  traffic_light_hex_seq #(
    .TICK_DIV (TICK_DIV),
    .GREEN_S  (9),
    .YELLOW_S (3),
    .RED_S    (9)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .force_red    (force_red),
    .lamp         (lamp),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus protocol invariants, checked every cycle on the falling edge.
  always @(negedge clk) begin
    checks++;
    if ((m_write_n !== ~m_chipselect) || (m_address !== 2'b00) ||
        (m_writedata[31:8] !== 24'h0)) begin
      errors++;
      $display("FAIL protocol: write_n=%b cs=%b addr=%0d wdata=%h", m_write_n,
               m_chipselect, m_address, m_writedata);
    end
  end

  // Apply a synchronous-looking reset pulse and leave the DUT idle.
  task automatic apply_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    enable    = 1'b0;
    force_red = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    force_red = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ((lamp !== 3'b000) || (m_chipselect !== 1'b0) || (m_write_n !== 1'b1) ||
        (m_writedata !== 32'h0000_00FF) || (m_address !== 2'b00)) begin
      errors++;
      $display("FAIL reset_values: lamp=%b cs=%b wn=%b wdata=%h addr=%0d (want 000 0 1 000000ff 0)",
               lamp, m_chipselect, m_write_n, m_writedata, m_address);
    end
    reset_n = 1'b1;
    begin
      int wr_cnt = 0;
      repeat (10) begin
        @(negedge clk);
        if (m_chipselect === 1'b1) wr_cnt++;
      end
      checks++;
      if (wr_cnt != 0) begin
        errors++;
        $display("FAIL idle_no_write: writes=%0d want 0", wr_cnt);
      end
    end
  endtask

  // One full loop plus the return to GREEN: 22 writes spaced TICK_DIV apart.
  task automatic test_full_loop();
    logic [7:0] exp_seg [22];
    logic [2:0] exp_lamp;
    exp_seg = '{8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9,
                8'h30, 8'h24, 8'h79,
                8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9,
                8'h90};
    apply_reset();
    enable = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k > 0) begin
        for (int j = 1; j < TICK_DIV; j++) begin
          @(negedge clk);
          checks++;
          if (m_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL loop_gap: step=%0d gap=%0d cs=%b want 0", k, j, m_chipselect);
          end
        end
      end
      @(negedge clk);
      if (k < 9)       exp_lamp = 3'b001;
      else if (k < 12) exp_lamp = 3'b010;
      else if (k < 21) exp_lamp = 3'b100;
      else             exp_lamp = 3'b001;
      checks++;
      if ((m_chipselect !== 1'b1) || (m_writedata !== {24'h0, exp_seg[k]}) ||
          (lamp !== exp_lamp)) begin
        errors++;
        $display("FAIL loop_write: step=%0d cs=%b wdata=%h lamp=%b want cs=1 wdata=%h lamp=%b",
                 k, m_chipselect, m_writedata, lamp, exp_seg[k], exp_lamp);
      end
    end
  endtask

  // force_red coincident with the tick that would have shown 4.
  task automatic test_force_red();
    logic [7:0] exp_seg [5];
    exp_seg = '{8'h90, 8'h80, 8'hF8, 8'h82, 8'h92};
    apply_reset();
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (TICK_DIV - 1) @(negedge clk);
      @(negedge clk);
      checks++;
      if ((m_chipselect !== 1'b1) || (m_writedata[7:0] !== exp_seg[k])) begin
        errors++;
        $display("FAIL force_pre: step=%0d cs=%b wdata=%h want 1 %h", k, m_chipselect,
                 m_writedata, exp_seg[k]);
      end
    end
    repeat (TICK_DIV - 2) @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL force_quiet: cs=%b want 0", m_chipselect);
    end
    force_red = 1'b1;
    @(negedge clk);
    force_red = 1'b0;
    checks++;
    if ((lamp !== 3'b100) || (m_chipselect !== 1'b1) || (m_writedata !== 32'h90)) begin
      errors++;
      $display("FAIL force_red_write: lamp=%b cs=%b wdata=%h want 100 1 00000090",
               lamp, m_chipselect, m_writedata);
    end
    for (int j = 1; j < TICK_DIV; j++) begin
      @(negedge clk);
      checks++;
      if (m_chipselect !== 1'b0) begin
        errors++;
        $display("FAIL force_gap: gap=%0d cs=%b wdata=%h want no write", j, m_chipselect,
                 m_writedata);
      end
    end
    @(negedge clk);
    checks++;
    if ((lamp !== 3'b100) || (m_chipselect !== 1'b1) || (m_writedata !== 32'h80)) begin
      errors++;
      $display("FAIL force_next_tick: lamp=%b cs=%b wdata=%h want 100 1 00000080",
               lamp, m_chipselect, m_writedata);
    end
  endtask

  // force_red together with enable from IDLE goes straight to RED.
  task automatic test_force_from_idle();
    apply_reset();
    enable    = 1'b1;
    force_red = 1'b1;
    @(negedge clk);
    force_red = 1'b0;
    checks++;
    if ((lamp !== 3'b100) || (m_chipselect !== 1'b1) || (m_writedata !== 32'h90)) begin
      errors++;
      $display("FAIL force_idle: lamp=%b cs=%b wdata=%h want 100 1 00000090",
               lamp, m_chipselect, m_writedata);
    end
  endtask

  task automatic test_enable_drop();
    int wr_cnt;
    apply_reset();
    enable = 1'b1;
    @(negedge clk);                     // GREEN entry
    repeat (9 * TICK_DIV) @(negedge clk);
    checks++;
    if ((lamp !== 3'b010) || (m_chipselect !== 1'b1) || (m_writedata !== 32'h30)) begin
      errors++;
      $display("FAIL yellow_entry: lamp=%b cs=%b wdata=%h want 010 1 00000030",
               lamp, m_chipselect, m_writedata);
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ((lamp !== 3'b000) || (m_chipselect !== 1'b1) || (m_writedata !== 32'hFF)) begin
      errors++;
      $display("FAIL drop_write: lamp=%b cs=%b wdata=%h want 000 1 000000ff",
               lamp, m_chipselect, m_writedata);
    end
    wr_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (m_chipselect === 1'b1) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 0) begin
      errors++;
      $display("FAIL drop_quiet: writes=%0d want 0", wr_cnt);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ((lamp !== 3'b001) || (m_chipselect !== 1'b1) || (m_writedata !== 32'h90)) begin
      errors++;
      $display("FAIL reenable: lamp=%b cs=%b wdata=%h want 001 1 00000090",
               lamp, m_chipselect, m_writedata);
    end
    repeat (TICK_DIV) @(negedge clk);
    checks++;
    if ((m_chipselect !== 1'b1) || (m_writedata !== 32'h80)) begin
      errors++;
      $display("FAIL reenable_tick: cs=%b wdata=%h want 1 00000080", m_chipselect, m_writedata);
    end
  endtask

  // GREEN entry write immediately followed by the IDLE blank write.
  task automatic test_back_to_back();
    apply_reset();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    checks++;
    if ((m_chipselect !== 1'b1) || (m_writedata !== 32'h90)) begin
      errors++;
      $display("FAIL b2b_first: cs=%b wdata=%h want 1 00000090", m_chipselect, m_writedata);
    end
    @(negedge clk);
    checks++;
    if ((m_chipselect !== 1'b1) || (m_writedata !== 32'hFF) || (lamp !== 3'b000)) begin
      errors++;
      $display("FAIL b2b_second: cs=%b wdata=%h lamp=%b want 1 000000ff 000",
               m_chipselect, m_writedata, lamp);
    end
    @(negedge clk);
    checks++;
    if (m_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: cs=%b want 0", m_chipselect);
    end
  endtask

  task automatic test_async_reset();
    int wr_cnt;
    apply_reset();
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (m_chipselect !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: cs=%b want 1", m_chipselect);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ((m_chipselect !== 1'b0) || (m_write_n !== 1'b1) || (lamp !== 3'b000) ||
        (m_writedata !== 32'hFF)) begin
      errors++;
      $display("FAIL areset_now: cs=%b wn=%b lamp=%b wdata=%h want 0 1 000 000000ff",
               m_chipselect, m_write_n, lamp, m_writedata);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wr_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_chipselect === 1'b1) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 0) begin
      errors++;
      $display("FAIL areset_quiet: writes=%0d want 0", wr_cnt);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    force_red = 1'b0;
    test_reset();
    test_full_loop();
    test_force_red();
    test_force_from_idle();
    test_enable_drop();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
